// File: rtl/qenc_pkg.sv
// Shared types and helpers for the quadrature encoder speed block.
package qenc_pkg;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_FWD  = 2'd1,
    STEP_REV  = 2'd2,
    STEP_ERR  = 2'd3
  } step_e;

  typedef enum logic [1:0] {
    WIN_COUNT = 2'd0,
    WIN_LATCH = 2'd1,
    WIN_SCALE = 2'd2
  } win_state_e;

  // Bits needed to hold values 0..v-1 (0 for v <= 1).
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // 4x decode of filtered {A,B}; forward order is 00->01->11->10->00.
  function automatic step_e decode(input logic [1:0] prev, input logic [1:0] cur);
    step_e s;
    case ({prev, cur})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: s = STEP_FWD;
      4'b0010, 4'b1011, 4'b1101, 4'b0100: s = STEP_REV;
      4'b0011, 4'b1100, 4'b0110, 4'b1001: s = STEP_ERR;
      default:                            s = STEP_NONE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/quad_encoder_speed_filter.sv
// Two-flop synchroniser followed by a FILT_LEN-sample agreement filter.
module qenc_input_filter #(
  parameter int unsigned FILT_LEN = 3
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_lvl_c
);

  logic [1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_sync <= '0;
    else          r_sync <= {r_sync[0], i_d};
  end

  generate
    if (FILT_LEN > 1) begin : g_filt
      localparam int unsigned HW = FILT_LEN - 1;
      logic [HW-1:0] r_hist;
      logic          r_lvl;
      logic          w_agree;

      // The newest synchronised sample plus HW older ones must all agree.
      assign w_agree = (r_hist == {HW{r_sync[1]}});
      assign o_lvl_c = w_agree ? r_sync[1] : r_lvl;

      always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
          r_hist <= '0;
          r_lvl  <= 1'b0;
        end else begin
          r_hist <= HW'({r_hist, r_sync[1]});
          r_lvl  <= o_lvl_c;
        end
      end
    end else begin : g_pass
      assign o_lvl_c = r_sync[1];
    end
  endgenerate

endmodule

// File: rtl/quad_encoder_speed.sv
// Quadrature encoder front end: 4x decode, position count, windowed signed speed to RPM.
// Optional index-pulse position clear when QENC_INDEX_EN is defined.
module quad_encoder_speed
  import qenc_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = 500000,
  parameter int unsigned FILT_LEN    = 3,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned POS_W       = 32,
  parameter int unsigned RPM_W       = 8,
  parameter int unsigned RPM_MUL     = 1,
  parameter int unsigned RPM_SHIFT   = 0
) (
  input  logic                    cclk,
  input  logic                    rstb,
  input  logic                    a,
  input  logic                    b,
`ifdef QENC_INDEX_EN
  input  logic                    index,
`endif
  input  logic                    clr_pos,
  output logic [RPM_W-1:0]        rpm,
  output logic                    dir,
  output logic                    rpm_valid,
  output logic signed [POS_W-1:0] position,
  output logic                    trans_err
);

  localparam int unsigned WC_W   = (clog2(GATE_CYCLES) < 1) ? 1 : clog2(GATE_CYCLES);
  localparam int unsigned PROD_W = CNT_W + clog2(RPM_MUL + 1);
  localparam int unsigned CMP_W  = (PROD_W > RPM_W) ? PROD_W : RPM_W;
  localparam logic [WC_W-1:0] WIN_LAST = WC_W'(GATE_CYCLES - 1);
  localparam logic signed [CNT_W:0] ACC_MAX = (CNT_W+1)'((64'd1 << (CNT_W - 1)) - 64'd1);
  localparam logic signed [CNT_W:0] ACC_MIN = -ACC_MAX;

  localparam logic [1:0] S_COUNT = WIN_COUNT;
  localparam logic [1:0] S_LATCH = WIN_LATCH;
  localparam logic [1:0] S_SCALE = WIN_SCALE;

  logic                    w_a, w_b, w_clr;
  logic [1:0]              r_ab_prev;
  step_e                   w_step;
  logic signed [CNT_W:0]   w_acc_delta, w_acc_sum;
  logic signed [CNT_W-1:0] w_acc_sat, w_acc_nxt, w_snap_nxt;
  logic signed [POS_W-1:0] w_pos_delta;
  logic [1:0]              r_state, w_state_nxt;
  logic [WC_W-1:0]         r_win_cnt, w_win_cnt_nxt;
  logic signed [CNT_W-1:0] r_acc, r_snap;
  logic signed [POS_W-1:0] r_pos;
  logic [RPM_W-1:0]        r_rpm, w_rpm;
  logic                    r_dir, r_rpm_valid, r_trans_err;
  logic [CNT_W-1:0]        w_mag;
  logic [PROD_W-1:0]       w_prod;
  logic [CMP_W-1:0]        w_scaled;

  qenc_input_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
    .i_clk(cclk), .i_rst_n(rstb), .i_d(a), .o_lvl_c(w_a)
  );
  qenc_input_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
    .i_clk(cclk), .i_rst_n(rstb), .i_d(b), .o_lvl_c(w_b)
  );

`ifdef QENC_INDEX_EN
  logic w_idx, r_idx_prev;

  qenc_input_filter #(.FILT_LEN(FILT_LEN)) u_filt_idx (
    .i_clk(cclk), .i_rst_n(rstb), .i_d(index), .o_lvl_c(w_idx)
  );

  always_ff @(posedge cclk) begin
    if (!rstb) r_idx_prev <= 1'b0;
    else       r_idx_prev <= w_idx;
  end

  assign w_clr = clr_pos | (w_idx & ~r_idx_prev);
`else
  assign w_clr = clr_pos;
`endif

  assign w_step = decode(r_ab_prev, {w_a, w_b});

  always_comb begin
    w_acc_delta = '0;
    w_pos_delta = '0;
    case (w_step)
      STEP_FWD: begin
        w_acc_delta = (CNT_W+1)'(1);
        w_pos_delta = POS_W'(1);
      end
      STEP_REV: begin
        w_acc_delta = '1;
        w_pos_delta = '1;
      end
      default: ;
    endcase
  end

  // Accumulator holds at the symmetric limit instead of wrapping.
  assign w_acc_sum = $signed({r_acc[CNT_W-1], r_acc}) + w_acc_delta;
  assign w_acc_sat = (w_acc_sum > ACC_MAX) ? CNT_W'(ACC_MAX) :
                     (w_acc_sum < ACC_MIN) ? CNT_W'(ACC_MIN) : CNT_W'(w_acc_sum);

  assign w_win_cnt_nxt = (r_win_cnt == WIN_LAST) ? '0 : r_win_cnt + WC_W'(1);

  // Window FSM: the terminal step goes into the snapshot so no edge is lost.
  always_comb begin
    w_state_nxt = S_COUNT;
    w_acc_nxt   = w_acc_sat;
    w_snap_nxt  = r_snap;
    case (r_state)
      S_LATCH: begin
        w_state_nxt = S_SCALE;
        w_acc_nxt   = '0;
        w_snap_nxt  = w_acc_sat;
      end
      default: begin
        if (w_win_cnt_nxt == WIN_LAST) w_state_nxt = S_LATCH;
      end
    endcase
  end

  assign w_mag    = r_snap[CNT_W-1] ? CNT_W'($unsigned(-r_snap)) : CNT_W'($unsigned(r_snap));
  assign w_prod   = PROD_W'(w_mag) * PROD_W'(RPM_MUL);
  assign w_scaled = CMP_W'(w_prod >> RPM_SHIFT);
  assign w_rpm    = (w_scaled > CMP_W'({RPM_W{1'b1}})) ? '1 : RPM_W'(w_scaled);

  always_ff @(posedge cclk) begin
    if (!rstb) begin
      r_state     <= S_COUNT;
      r_win_cnt   <= '0;
      r_acc       <= '0;
      r_snap      <= '0;
      r_ab_prev   <= 2'b00;
      r_pos       <= '0;
      r_rpm       <= '0;
      r_dir       <= 1'b0;
      r_rpm_valid <= 1'b0;
      r_trans_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_win_cnt   <= w_win_cnt_nxt;
      r_acc       <= w_acc_nxt;
      r_snap      <= w_snap_nxt;
      r_ab_prev   <= {w_a, w_b};
      r_pos       <= w_clr ? '0 : r_pos + w_pos_delta;
      r_rpm_valid <= (r_state == S_SCALE);
      if (r_state == S_SCALE) begin
        r_rpm <= w_rpm;
        r_dir <= r_snap[CNT_W-1];
      end
      if (clr_pos)                r_trans_err <= 1'b0;
      else if (w_step == STEP_ERR) r_trans_err <= 1'b1;
    end
  end

  assign rpm       = r_rpm;
  assign dir       = r_dir;
  assign rpm_valid = r_rpm_valid;
  assign position  = r_pos;
  assign trans_err = r_trans_err;

endmodule

// File: tb/tb_quad_encoder_speed.sv
// Directed bench for quad_encoder_speed: reset, window boundary, glitch/illegal, clear, speed table.
module tb_quad_encoder_speed;

  localparam int G = 1000;

  logic               cclk = 1'b0;
  logic               rstb, a, b, clr_pos, index;
  logic [7:0]         rpm;
  logic               dir, rpm_valid, trans_err;
  logic signed [31:0] position;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int q_ph    = 0;
  longint exp_pos = 0;
  int q_rpm[$];
  int q_dir[$];

  typedef struct {
    logic rev;
    int   period;
    int   exp_rpm;
    logic exp_dir;
  } vec_t;
  vec_t vecs[6];

  quad_encoder_speed #(
    .GATE_CYCLES(G), .FILT_LEN(3), .CNT_W(16), .POS_W(32),
    .RPM_W(8), .RPM_MUL(3), .RPM_SHIFT(1)
  ) dut (
    .cclk(cclk), .rstb(rstb), .a(a), .b(b),
`ifdef QENC_INDEX_EN
    .index(index),
`endif
    .clr_pos(clr_pos), .rpm(rpm), .dir(dir), .rpm_valid(rpm_valid),
    .position(position), .trans_err(trans_err)
  );

  always #5 cclk = ~cclk;

  always @(posedge cclk) begin
    if (!rstb) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  always @(negedge cclk) begin
    if (rstb && rpm_valid) begin
      q_rpm.push_back(int'(rpm));
      q_dir.push_back(int'(dir));
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_ab();
    case (q_ph)
      0:       {a, b} = 2'b00;
      1:       {a, b} = 2'b01;
      2:       {a, b} = 2'b11;
      default: {a, b} = 2'b10;
    endcase
  endtask

  task automatic step_q(input logic rev);
    q_ph = rev ? (q_ph + 3) % 4 : (q_ph + 1) % 4;
    exp_pos += rev ? -1 : 1;
    drive_ab();
  endtask

  task automatic drive_stream(input logic rev, input int period, input int ncyc);
    for (int k = 0; k < ncyc / period; k++) begin
      step_q(rev);
      repeat (period) @(negedge cclk);
    end
  endtask

  task automatic wait_cyc(input int t);
    for (int k = 0; k < 5000 && cyc != t; k++) @(negedge cclk);
    check("wait_cyc_reached", cyc, t);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    vecs[0] = '{1'b0, 10, 150, 1'b0};
    vecs[1] = '{1'b1, 20,  75, 1'b1};
    vecs[2] = '{1'b1,  8, 187, 1'b1};
    vecs[3] = '{1'b0,  5, 255, 1'b0};
    vecs[4] = '{1'b1,  4, 255, 1'b1};
    vecs[5] = '{1'b0, 25,  60, 1'b0};

    rstb = 1'b0; a = 1'b0; b = 1'b0; clr_pos = 1'b0; index = 1'b0;

    // Reset held 3 cycles with inputs toggling.
    for (int k = 0; k < 3; k++) begin
      @(negedge cclk);
      a = ~a;
      b = (k == 1);
    end
    @(negedge cclk);
    a = 1'b0; b = 1'b0;
    check("rst_rpm", rpm, 0);
    check("rst_dir", dir, 0);
    check("rst_rpm_valid", rpm_valid, 0);
    check("rst_position", position, 0);
    check("rst_trans_err", trans_err, 0);
    rstb = 1'b1;

    first = -1;
    for (int k = 0; k < 3 * G && first < 0; k++) begin
      @(negedge cclk);
      if (rpm_valid) first = cyc;
    end
    check("first_valid_cycle", first, G + 1);
    check("first_rpm", rpm, 0);
    check("first_dir", dir, 0);
    @(negedge cclk);
    check("valid_one_cycle", rpm_valid, 0);
    q_rpm.delete(); q_dir.delete();

    // Edge decoded on the terminal cycle belongs to the closing window.
    wait_cyc(2 * G - 5);
    step_q(1'b0);
    // Edge decoded on the first cycle belongs to the new window.
    wait_cyc(3 * G - 4);
    step_q(1'b1);
    wait_cyc(4 * G + 3);
    check("bnd_reports", q_rpm.size(), 3);
    if (q_rpm.size() == 3) begin
      check("bnd_w2_rpm", q_rpm[0], 1);
      check("bnd_w2_dir", q_dir[0], 0);
      check("bnd_w3_rpm", q_rpm[1], 0);
      check("bnd_w3_dir", q_dir[1], 0);
      check("bnd_w4_rpm", q_rpm[2], 1);
      check("bnd_w4_dir", q_dir[2], 1);
    end
    check("bnd_position", position, exp_pos);

    // Two-cycle glitch on A is rejected by the filter.
    a = ~a;
    repeat (2) @(negedge cclk);
    a = ~a;
    repeat (10) @(negedge cclk);
    check("glitch_position", position, exp_pos);
    check("glitch_trans_err", trans_err, 0);

    // Simultaneous A/B flip is illegal.
    q_ph = (q_ph + 2) % 4;
    drive_ab();
    repeat (8) @(negedge cclk);
    check("illegal_trans_err", trans_err, 1);
    check("illegal_position", position, exp_pos);

    for (int k = 0; k < 3; k++) begin
      step_q(1'b0);
      repeat (6) @(negedge cclk);
    end
    repeat (6) @(negedge cclk);
    check("pre_clr_position", position, exp_pos);

    // clr_pos lands on the same cycle as a decoded step.
    step_q(1'b0);
    repeat (4) @(negedge cclk);
    clr_pos = 1'b1;
    exp_pos = 0;
    @(negedge cclk);
    clr_pos = 1'b0;
    repeat (10) @(negedge cclk);
    check("clr_position", position, 0);
    check("clr_trans_err", trans_err, 0);

    for (int v = 0; v < 6; v++) begin
      q_rpm.delete(); q_dir.delete();
      drive_stream(vecs[v].rev, vecs[v].period, 3 * G);
      check($sformatf("vec%0d_reports", v), (q_rpm.size() > 0) ? 1 : 0, 1);
      if (q_rpm.size() > 0) begin
        check($sformatf("vec%0d_rpm", v), q_rpm[q_rpm.size()-1], vecs[v].exp_rpm);
        check($sformatf("vec%0d_dir", v), q_dir[q_dir.size()-1], vecs[v].exp_dir);
      end
      repeat (10) @(negedge cclk);
      check($sformatf("vec%0d_position", v), position, exp_pos);
    end

`ifdef QENC_INDEX_EN
    clr_pos = 1'b1;
    exp_pos = 0;
    @(negedge cclk);
    clr_pos = 1'b0;
    for (int k = 0; k < 57; k++) begin
      step_q(1'b0);
      repeat (6) @(negedge cclk);
    end
    repeat (6) @(negedge cclk);
    check("idx_pre_position", position, 57);
    index = 1'b1;
    exp_pos = 0;
    repeat (4) @(negedge cclk);
    index = 1'b0;
    repeat (10) @(negedge cclk);
    check("idx_position", position, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
